// File: rtl/pipe_adder_if.sv
// Operation/result bundle for pipe_adder: the source drives the operation and
// pipeline enable; the adder returns the registered result.
interface pipe_adder_if #(
  parameter int W = 16
);
  logic         en;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  modport master (
    output en, in_valid, a, b, c_in, sub,
    input  out_valid, sum, c_out, ovf
  );

  modport slave (
    input  en, in_valid, a, b, c_in, sub,
    output out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined W-bit add/subtract: one CW-bit ripple slice per stage, carry
// registered between stages, outputs driven straight from the last stage.
module pipe_adder #(
  parameter int W      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_adder_if.slave  bus
);
  localparam int CW = W / STAGES;

  logic [W-1:0] w_be;
  logic         w_ce;

  assign w_be = bus.sub ? ~bus.b : bus.b;
  assign w_ce = bus.c_in ^ bus.sub;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int LO = s * CW;
    localparam int HI = LO + CW;

    // Operand views start at this stage's slice; upper bits are still pending.
    logic [W-LO-1:0] w_ain;
    logic [W-LO-1:0] w_bin;
    logic            w_vin;
    logic            w_ci;
    logic            w_amsb;
    logic            w_bmsb;
    logic [CW:0]     w_res;
    logic [HI-1:0]   w_sum;

    logic            r_vld;
    logic            r_cy;
    logic [HI-1:0]   r_sum;

    if (s == 0) begin : g_src
      assign w_vin  = bus.in_valid;
      assign w_ain  = bus.a;
      assign w_bin  = w_be;
      assign w_ci   = w_ce;
      assign w_amsb = bus.a[W-1];
      assign w_bmsb = w_be[W-1];
    end else begin : g_src
      assign w_vin  = g_stg[s-1].r_vld;
      assign w_ain  = g_stg[s-1].g_fwd.r_a;
      assign w_bin  = g_stg[s-1].g_fwd.r_be;
      assign w_ci   = g_stg[s-1].r_cy;
      assign w_amsb = g_stg[s-1].g_fwd.r_amsb;
      assign w_bmsb = g_stg[s-1].g_fwd.r_bmsb;
    end

    assign w_res = {1'b0, w_ain[CW-1:0]} + {1'b0, w_bin[CW-1:0]} + {{CW{1'b0}}, w_ci};

    if (s == 0) begin : g_acc
      assign w_sum = w_res[CW-1:0];
    end else begin : g_acc
      assign w_sum = {w_res[CW-1:0], g_stg[s-1].r_sum};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
        r_sum <= '0;
      end else if (bus.en) begin
        r_vld <= w_vin;
        r_cy  <= w_res[CW];
        r_sum <= w_sum;
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      logic [W-HI-1:0] r_a;
      logic [W-HI-1:0] r_be;
      logic            r_amsb;
      logic            r_bmsb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a    <= '0;
          r_be   <= '0;
          r_amsb <= 1'b0;
          r_bmsb <= 1'b0;
        end else if (bus.en) begin
          r_a    <= w_ain[W-LO-1:CW];
          r_be   <= w_bin[W-LO-1:CW];
          r_amsb <= w_amsb;
          r_bmsb <= w_bmsb;
        end
      end
    end else begin : g_lst
      logic r_ovf;

      // Overflow is resolved while loading the last slice so ovf is a plain register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (bus.en) begin
          r_ovf <= (w_amsb == w_bmsb) && (w_res[CW-1] != w_amsb);
        end
      end

      assign bus.out_valid = r_vld;
      assign bus.sum       = r_sum;
      assign bus.c_out     = r_cy;
      assign bus.ovf       = r_ovf;
    end
  end
endmodule
